tmds_dec: RTL and testbench



---
 rtl/tmds_dec.sv | 205 ++++++++++++++++++++
 tb/tb_tmds_dec.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/tmds_dec.sv
// tmds_dec -- TMDS receive-side character aligner and 10b/8b decoder.
//
// One instance per TMDS channel. Raw 10-bit characters from the deserializer
// are registered (stage 1), the aligner FSM searches for a run of control
// tokens and requests bitslips until the character boundary is found, and the
// decoded pixel byte or control pair is registered (stage 2).
//
// Ports:
//   clk_i          pixel clock
//   rst_n_i        asynchronous active-low reset
//   tmds_data_i    raw TMDS character, bit 0 first on the wire
//   bitslip_o      one-cycle request to shift the deserializer boundary by 1 bit
//   locked_o       character alignment achieved
//   px_data_o      decoded pixel byte (holds outside data periods)
//   px_data_val_o  px_data_o updated by a data character this cycle
//   ctl_0_o/ctl_1_o decoded control bits C0/C1 (hold outside control periods)
//   ctl_val_o      ctl_*_o updated by a control token this cycle
//   err_cnt_o      (only with TMDS_DEC_ERR_CNT_EN) saturating count of lock
//                  losses and control-token changes within a control period
//
// Optional feature macro: TMDS_DEC_ERR_CNT_EN.

module tmds_dec #(
    parameter int CTL_LOCK_CNT = 16,
    parameter int SLIP_WAIT    = 8,
    parameter int MAX_DATA_RUN = 4096
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic [9:0] tmds_data_i,
    output logic       bitslip_o,
    output logic       locked_o,
    output logic [7:0] px_data_o,
    output logic       px_data_val_o,
    output logic       ctl_0_o,
    output logic       ctl_1_o,
    output logic       ctl_val_o
`ifdef TMDS_DEC_ERR_CNT_EN
    ,
    output logic [15:0] err_cnt_o
`endif
);

    localparam int TOK_W  = $clog2(CTL_LOCK_CNT + 1);
    localparam int SRCH_W = $clog2(2 * CTL_LOCK_CNT + 1);
    localparam int WAIT_W = $clog2(SLIP_WAIT + 1);
    localparam int RUN_W  = $clog2(MAX_DATA_RUN + 1);

    typedef enum logic [1:0] {
        ST_SEARCH,
        ST_SLIP,
        ST_WAIT,
        ST_LOCKED
    } state_t;

    state_t            state;
    logic [9:0]        d1;
    logic [TOK_W-1:0]  tok_cnt;
    logic [SRCH_W-1:0] srch_cnt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [RUN_W-1:0]  run_cnt;

    logic       is_tok;
    logic [1:0] tok_ctl;
    logic [7:0] d;
    logic [7:0] dec;
    logic       go_lock;
    logic       drop_lock;
    logic       out_en;

`ifdef TMDS_DEC_ERR_CNT_EN
    logic       in_ctl;
    logic [1:0] prev_ctl;
`endif

    // Token match and data decode on the stage-1 character.
    always_comb begin
        is_tok  = 1'b1;
        tok_ctl = 2'b00;
        case (d1)
            10'b1101010100: tok_ctl = 2'b00;
            10'b0010101011: tok_ctl = 2'b01;
            10'b0101010100: tok_ctl = 2'b10;
            10'b1010101011: tok_ctl = 2'b11;
            default:        is_tok  = 1'b0;
        endcase
        d      = d1[9] ? ~d1[7:0] : d1[7:0];
        dec    = 8'h00;
        dec[0] = d[0];
        for (int i = 1; i < 8; i++)
            dec[i] = d1[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    end

    // The token completing the lock count is already treated as locked, and
    // the character that exhausts the data run is already treated as unlocked,
    // so locked_o and the output valids always move together.
    assign go_lock   = (state == ST_SEARCH) && is_tok &&
                       (tok_cnt == TOK_W'(CTL_LOCK_CNT - 1));
    assign drop_lock = (state == ST_LOCKED) && !is_tok &&
                       (run_cnt >= RUN_W'(MAX_DATA_RUN - 1));
    assign out_en    = go_lock || ((state == ST_LOCKED) && !drop_lock);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state         <= ST_SEARCH;
            d1            <= '0;
            tok_cnt       <= '0;
            srch_cnt      <= '0;
            wait_cnt      <= '0;
            run_cnt       <= '0;
            bitslip_o     <= 1'b0;
            locked_o      <= 1'b0;
            px_data_o     <= '0;
            px_data_val_o <= 1'b0;
            ctl_0_o       <= 1'b0;
            ctl_1_o       <= 1'b0;
            ctl_val_o     <= 1'b0;
`ifdef TMDS_DEC_ERR_CNT_EN
            err_cnt_o     <= '0;
            in_ctl        <= 1'b0;
            prev_ctl      <= 2'b00;
`endif
        end else begin
            d1        <= tmds_data_i;
            bitslip_o <= 1'b0;

            case (state)
                ST_SEARCH: begin
                    if (go_lock) begin
                        state    <= ST_LOCKED;
                        locked_o <= 1'b1;
                        run_cnt  <= '0;
                    end else if (srch_cnt == SRCH_W'(2 * CTL_LOCK_CNT - 1)) begin
                        state     <= ST_SLIP;
                        bitslip_o <= 1'b1;
                        srch_cnt  <= '0;
                        tok_cnt   <= '0;
                    end else begin
                        srch_cnt <= srch_cnt + 1'b1;
                        if (!is_tok)
                            tok_cnt <= '0;
                        else if (tok_cnt < TOK_W'(CTL_LOCK_CNT))
                            tok_cnt <= tok_cnt + 1'b1;
                    end
                end
                ST_SLIP: begin
                    state    <= ST_WAIT;
                    wait_cnt <= '0;
                end
                ST_WAIT: begin
                    // Input is ignored while the deserializer settles.
                    if (wait_cnt == WAIT_W'(SLIP_WAIT - 1)) begin
                        state    <= ST_SEARCH;
                        tok_cnt  <= '0;
                        srch_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: begin // ST_LOCKED
                    if (drop_lock) begin
                        state    <= ST_SEARCH;
                        locked_o <= 1'b0;
                        run_cnt  <= '0;
                        tok_cnt  <= '0;
                        srch_cnt <= '0;
                    end else if (is_tok) begin
                        run_cnt <= '0;
                    end else if (run_cnt < RUN_W'(MAX_DATA_RUN)) begin
                        run_cnt <= run_cnt + 1'b1;
                    end
                end
            endcase

            // Stage 2: registered decode.
            if (out_en && is_tok) begin
                ctl_val_o     <= 1'b1;
                px_data_val_o <= 1'b0;
                ctl_0_o       <= tok_ctl[0];
                ctl_1_o       <= tok_ctl[1];
            end else if (out_en) begin
                ctl_val_o     <= 1'b0;
                px_data_val_o <= 1'b1;
                px_data_o     <= dec;
            end else begin
                ctl_val_o     <= 1'b0;
                px_data_val_o <= 1'b0;
            end

`ifdef TMDS_DEC_ERR_CNT_EN
            // A control period is an unbroken run of locked control tokens.
            if (out_en && is_tok) begin
                in_ctl   <= 1'b1;
                prev_ctl <= tok_ctl;
            end else begin
                in_ctl   <= 1'b0;
            end
            if ((drop_lock || (out_en && is_tok && in_ctl && (tok_ctl != prev_ctl))) &&
                (err_cnt_o != 16'hFFFF))
                err_cnt_o <= err_cnt_o + 1'b1;
`endif
        end
    end

endmodule

// File: tb/tb_tmds_dec.sv
// Scoreboard bench for tmds_dec: stimulus pushes expected decoded outputs,
// a negedge monitor pops and compares whenever the DUT flags a valid output.
module tb_tmds_dec;

    logic       clk_i = 1'b0;
    logic       rst_n_i = 1'b0;
    logic [9:0] tmds_data_i = '0;
    logic       bitslip_o, locked_o, px_data_val_o, ctl_0_o, ctl_1_o, ctl_val_o;
    logic [7:0] px_data_o;
`ifdef TMDS_DEC_ERR_CNT_EN
    logic [15:0] err_cnt_o;
`endif

    tmds_dec dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .tmds_data_i(tmds_data_i),
        .bitslip_o(bitslip_o), .locked_o(locked_o), .px_data_o(px_data_o),
        .px_data_val_o(px_data_val_o), .ctl_0_o(ctl_0_o), .ctl_1_o(ctl_1_o),
        .ctl_val_o(ctl_val_o)
`ifdef TMDS_DEC_ERR_CNT_EN
        , .err_cnt_o(err_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    localparam logic [9:0] T00 = 10'b1101010100;
    localparam logic [9:0] T01 = 10'b0010101011;
    localparam logic [9:0] T11 = 10'b1010101011;

    typedef struct packed {
        logic       is_ctl;
        logic [1:0] ctl;
        logic [7:0] data;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   slip_total = 0;
    bit   prev_slip = 0;
    bit   free_mode = 0;
    logic [1:0] last_ctl = 2'b00;
    logic [7:0] last_data = 8'h00;

    logic [9:0] dch[4];
    logic [7:0] dexp[4];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic send(input logic [9:0] c, input bit exp_out, input bit is_ctl,
                        input logic [1:0] ctl, input logic [7:0] dat);
        exp_t e;
        @(negedge clk_i);
        tmds_data_i = c;
        if (exp_out) begin
            e.is_ctl = is_ctl;
            e.ctl    = ctl;
            e.data   = dat;
            q.push_back(e);
        end
    endtask

    function automatic logic [9:0] rot(input int k);
        logic [19:0] w;
        w = {T00, T00};
        return w[k +: 10];
    endfunction

    // Monitor / scoreboard
    always @(negedge clk_i) begin
        exp_t e;
        if (rst_n_i) begin
            if (bitslip_o) begin
                slip_total++;
                if (prev_slip) check("slip_back_to_back", 1, 0);
            end
            prev_slip = bitslip_o;
            if (px_data_val_o && ctl_val_o) check("both_valid", 1, 0);
            if (free_mode) begin
                if (px_data_val_o) check("free_px_val", 1, 0);
                if (ctl_val_o) check("free_ctl", {ctl_1_o, ctl_0_o}, 2'b00);
            end else if (px_data_val_o || ctl_val_o) begin
                if (q.size() == 0) begin
                    check("unexpected_output", {ctl_val_o, px_data_val_o}, 0);
                end else begin
                    e = q.pop_front();
                    check("out_kind_ctl", ctl_val_o, e.is_ctl);
                    if (e.is_ctl) begin
                        check("ctl_value", {ctl_1_o, ctl_0_o}, e.ctl);
                        check("px_hold", px_data_o, last_data);
                        last_ctl = e.ctl;
                    end else begin
                        check("px_value", px_data_o, e.data);
                        check("ctl_hold", {ctl_1_o, ctl_0_o}, last_ctl);
                        last_data = e.data;
                    end
                end
            end
        end else begin
            prev_slip = 0;
        end
    end

    initial begin
        #400000;
        $display("FAIL timeout act=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int slip_t[8];
        int ns, k, c, s0;
`ifdef TMDS_DEC_ERR_CNT_EN
        logic [15:0] e0;
`endif
        dch[0] = 10'b0100000000; dexp[0] = 8'h00;
        dch[1] = 10'b1011111111; dexp[1] = 8'hFE;
        dch[2] = 10'b0011110000; dexp[2] = 8'hEE;
        dch[3] = 10'b1100110101; dexp[3] = 8'h5E;

        // Reset state
        repeat (3) @(negedge clk_i);
        check("rst_outputs", {bitslip_o, locked_o, px_data_val_o, ctl_val_o,
                              ctl_1_o, ctl_0_o, px_data_o}, 0);
`ifdef TMDS_DEC_ERR_CNT_EN
        check("rst_err_cnt", err_cnt_o, 0);
`endif
        rst_n_i = 1'b1;

        // Aligned stream: lock on the 16th token, which is itself output.
        for (int i = 1; i <= 16; i++) send(T00, i == 16, 1, 2'b00, 8'h00);
        send(T00, 1, 1, 2'b00, 8'h00);
        check("locked_before", locked_o, 0);
        send(T00, 1, 1, 2'b00, 8'h00);
        check("locked_after_16", locked_o, 1);
        send(T00, 1, 1, 2'b00, 8'h00);
        send(T00, 1, 1, 2'b00, 8'h00);
        check("no_slip_aligned", slip_total, 0);

        // Data decode vectors, then a token to check hold behaviour.
        for (int i = 0; i < 4; i++) send(dch[i], 1, 0, 2'b00, dexp[i]);
        send(10'b0100000001, 1, 0, 2'b00, 8'h03);
        send(dch[3], 1, 0, 2'b00, dexp[3]);
        send(T00, 1, 1, 2'b00, 8'h00);

        // Alternating control tokens 01/11.
`ifdef TMDS_DEC_ERR_CNT_EN
        e0 = err_cnt_o;
`endif
        for (int i = 0; i < 16; i++) begin
            if (i % 2 == 0) send(T01, 1, 1, 2'b01, 8'h00);
            else            send(T11, 1, 1, 2'b11, 8'h00);
        end

        // Long data run: 4095 chars tolerated, the 4096th drops lock.
        for (int i = 1; i <= 4096; i++) begin
            send(dch[i % 4], i < 4096, 0, 2'b00, dexp[i % 4]);
`ifdef TMDS_DEC_ERR_CNT_EN
            if (i == 2) check("err_ctl_changes", err_cnt_o, e0 + 16'd16);
`endif
        end
        send(T00, 0, 0, 2'b00, 8'h00);
        check("locked_hold_run", locked_o, 1);
        send(T00, 0, 0, 2'b00, 8'h00);
        check("locked_drop_run", locked_o, 0);
        check("px_val_after_drop", px_data_val_o, 0);
        check("queue_drained", q.size(), 0);
`ifdef TMDS_DEC_ERR_CNT_EN
        check("err_lock_loss", err_cnt_o, e0 + 16'd17);
`endif

        // Misaligned stream: three slips needed to realign.
        rst_n_i   = 1'b0;
        free_mode = 1;
        @(negedge clk_i);
        check("rst_mid_px", {px_data_o, locked_o}, 0);
        k = 7;
        tmds_data_i = rot(k);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        ns = 0;
        c  = 0;
        while (c < 400 && !locked_o) begin
            @(negedge clk_i);
            if (bitslip_o) begin
                if (ns < 8) slip_t[ns] = c;
                ns++;
                k = (k + 1) % 10;
            end
            tmds_data_i = rot(k);
            c++;
        end
        check("rot_locked", locked_o, 1);
        check("rot_slip_count", ns, 3);
        for (int i = 1; i < 3 && i < ns; i++)
            check("rot_slip_spacing", (slip_t[i] - slip_t[i-1]) >= 41, 1);

        // Reset during a slip pulse, then re-lock from SEARCH.
        rst_n_i = 1'b0;
        @(negedge clk_i);
        k = 4;
        tmds_data_i = rot(k);
        rst_n_i = 1'b1;
        c = 0;
        while (c < 100 && !bitslip_o) begin
            @(negedge clk_i);
            c++;
        end
        check("slip_seen", bitslip_o, 1);
        rst_n_i = 1'b0;
        #1;
        check("async_rst", {bitslip_o, locked_o, px_data_val_o, ctl_val_o,
                            ctl_1_o, ctl_0_o, px_data_o}, 0);
        @(negedge clk_i);
        tmds_data_i = T00;
        rst_n_i = 1'b1;
        s0 = slip_total;
        c = 0;
        while (c < 60 && !locked_o) begin
            @(negedge clk_i);
            c++;
        end
        check("relock", locked_o, 1);
        check("relock_fast", c <= 24, 1);
        check("relock_no_slip", slip_total, s0);

        repeat (4) @(negedge clk_i);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
